// File: rtl/prenorm_pipe_if.sv
// prenorm_pipe_if: shared valid/ready bus for the denormal pre-normaliser.
//   slave  : the pre-normaliser (accepts in_*, produces out_*)
//   master : the upstream/downstream environment
//   in_valid/in_ready/in_mant/in_exp     : input transaction, all lanes packed
//   out_valid/out_ready/out_mant/out_exp : output transaction
//   out_shift/out_denorm/out_zero        : per-lane normalisation results
interface prenorm_pipe_if #(
    parameter int unsigned MANT_W = 23,
    parameter int unsigned EXP_W  = 8,
    parameter int unsigned LANES  = 2,
    parameter int unsigned SHW    = $clog2(MANT_W + 1)
);
    logic                      in_valid;
    logic                      in_ready;
    logic [LANES*MANT_W-1:0]   in_mant;
    logic [LANES*EXP_W-1:0]    in_exp;
    logic                      out_valid;
    logic                      out_ready;
    logic [LANES*MANT_W-1:0]   out_mant;
    logic [LANES*EXP_W-1:0]    out_exp;
    logic [LANES*SHW-1:0]      out_shift;
    logic [LANES-1:0]          out_denorm;
    logic [LANES-1:0]          out_zero;

    modport slave (
        input  in_valid, in_mant, in_exp, out_ready,
        output in_ready, out_valid, out_mant, out_exp, out_shift, out_denorm, out_zero
    );

    modport master (
        output in_valid, in_mant, in_exp, out_ready,
        input  in_ready, out_valid, out_mant, out_exp, out_shift, out_denorm, out_zero
    );
endinterface

// File: rtl/prenorm_pipe.sv
// prenorm_pipe: two-stage, multi-lane denormal pre-normaliser.
// Each lane is classified as normal / denormal / zero; denormals are left-shifted
// so the leading one lands in (and is dropped into) the implicit bit position.
// Ports:
//   clk, reset   : rising-edge clock, synchronous active-high reset
//   bus (slave)  : input/output valid-ready transaction, see prenorm_pipe_if
//   denorm_cnt   : saturating count of denormal lanes in consumed results
module prenorm_pipe #(
    parameter int unsigned MANT_W = 23,
    parameter int unsigned EXP_W  = 8,
    parameter int unsigned LANES  = 2,
    parameter int unsigned SHW    = $clog2(MANT_W + 1),
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    prenorm_pipe_if.slave     bus,
    output logic [CNT_W-1:0]  denorm_cnt
);
    localparam int unsigned PCW   = $clog2(LANES + 1);
    localparam int unsigned SUM_W = CNT_W + PCW;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Leading-zero count of a non-zero mantissa (value for zero is unused).
    function automatic logic [SHW-1:0] lead_zeros(input logic [MANT_W-1:0] m);
        logic [SHW-1:0] r;
        r = '0;
        for (int unsigned b = 0; b < MANT_W; b++) begin
            if (m[b]) r = SHW'(MANT_W - 1 - b);
        end
        return r;
    endfunction

    logic                    s1_en, s2_en, consume;
    logic                    s1_valid, s2_valid;
    logic [LANES*MANT_W-1:0] s1_mant, s2_mant, n_mant;
    logic [LANES*EXP_W-1:0]  s1_exp, s2_exp;
    logic [LANES*SHW-1:0]    s1_lzc, c_lzc, s2_shift, n_shift;
    logic [LANES-1:0]        s1_denorm, s1_zero, c_denorm, c_zero;
    logic [LANES-1:0]        s2_denorm, s2_zero;
    logic [PCW-1:0]          pop;
    logic [SUM_W-1:0]        cnt_sum;
    logic [CNT_W-1:0]        cnt_nxt;

    // Pipeline enables: a stage advances when it is empty or its successor advances.
    assign s2_en        = !s2_valid || bus.out_ready;
    assign s1_en        = !s1_valid || s2_en;
    assign consume      = s2_valid && bus.out_ready;
    assign bus.in_ready = s1_en;

    assign bus.out_valid  = s2_valid;
    assign bus.out_mant   = s2_mant;
    assign bus.out_exp    = s2_exp;
    assign bus.out_shift  = s2_shift;
    assign bus.out_denorm = s2_denorm;
    assign bus.out_zero   = s2_zero;

    // Stage-1 lane classification and leading-zero count.
    always_comb begin
        c_denorm = '0;
        c_zero   = '0;
        c_lzc    = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            c_zero[i]   = (bus.in_exp[i*EXP_W +: EXP_W] == '0) &&
                          (bus.in_mant[i*MANT_W +: MANT_W] == '0);
            c_denorm[i] = (bus.in_exp[i*EXP_W +: EXP_W] == '0) &&
                          (bus.in_mant[i*MANT_W +: MANT_W] != '0);
            c_lzc[i*SHW +: SHW] = lead_zeros(bus.in_mant[i*MANT_W +: MANT_W]);
        end
    end

    // Stage-2 shift: one extra position pushes the leading one out of the field.
    always_comb begin
        n_mant  = s1_mant;
        n_shift = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (s1_denorm[i]) begin
                n_shift[i*SHW +: SHW]   = s1_lzc[i*SHW +: SHW] + SHW'(1);
                n_mant[i*MANT_W +: MANT_W] =
                    s1_mant[i*MANT_W +: MANT_W] << n_shift[i*SHW +: SHW];
            end
        end
    end

    // Saturating accumulation of the consumed result's denormal lanes.
    always_comb begin
        pop     = PCW'($countones(s2_denorm));
        cnt_sum = SUM_W'(denorm_cnt) + SUM_W'(pop);
        cnt_nxt = (cnt_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : cnt_sum[CNT_W-1:0];
    end

    // Pipeline registers and counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid   <= 1'b0;
            s1_mant    <= '0;
            s1_exp     <= '0;
            s1_lzc     <= '0;
            s1_denorm  <= '0;
            s1_zero    <= '0;
            s2_valid   <= 1'b0;
            s2_mant    <= '0;
            s2_exp     <= '0;
            s2_shift   <= '0;
            s2_denorm  <= '0;
            s2_zero    <= '0;
            denorm_cnt <= '0;
        end else begin
            if (s1_en) begin
                s1_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_mant   <= bus.in_mant;
                    s1_exp    <= bus.in_exp;
                    s1_lzc    <= c_lzc;
                    s1_denorm <= c_denorm;
                    s1_zero   <= c_zero;
                end
            end
            if (s2_en) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_mant   <= n_mant;
                    s2_exp    <= s1_exp;
                    s2_shift  <= n_shift;
                    s2_denorm <= s1_denorm;
                    s2_zero   <= s1_zero;
                end
            end
            if (consume) denorm_cnt <= cnt_nxt;
        end
    end
endmodule

// File: tb/tb_prenorm_pipe.sv
// tb_prenorm_pipe: bench for prenorm_pipe (default instance plus a CNT_W=3 instance).
module tb_prenorm_pipe;
    localparam int unsigned MW  = 23;
    localparam int unsigned EW  = 8;
    localparam int unsigned L   = 2;
    localparam int unsigned SW  = 5;
    localparam int unsigned CW  = 16;
    localparam int unsigned CWC = 3;

    logic clk = 1'b0;
    logic reset;
    logic [CW-1:0]  cnt;
    logic [CWC-1:0] cnt_c;

    always #5 clk = ~clk;

    prenorm_pipe_if #(.MANT_W(MW), .EXP_W(EW), .LANES(L), .SHW(SW)) ifc ();
    prenorm_pipe_if #(.MANT_W(MW), .EXP_W(EW), .LANES(L), .SHW(SW)) ifc_c ();

    prenorm_pipe #(.MANT_W(MW), .EXP_W(EW), .LANES(L), .SHW(SW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .bus(ifc.slave), .denorm_cnt(cnt));
    prenorm_pipe #(.MANT_W(MW), .EXP_W(EW), .LANES(L), .SHW(SW), .CNT_W(CWC)) dut_c (
        .clk(clk), .reset(reset), .bus(ifc_c.slave), .denorm_cnt(cnt_c));

    typedef struct {
        logic [L*MW-1:0] mant;
        logic [L*EW-1:0] ex;
        logic [L*SW-1:0] sh;
        logic [L-1:0]    dn;
        logic [L-1:0]    zr;
        int              acc;
    } res_t;

    int   total = 0;
    int   bad   = 0;
    int   edge_n = 0;
    int   mcnt  = 0;
    bit   post_rst = 1'b0;
    res_t q[$];

    // Reference: double the mantissa until the top bit is set, then once more to drop it.
    function automatic res_t model(input logic [L*MW-1:0] m, input logic [L*EW-1:0] e);
        res_t r;
        logic [MW-1:0] v;
        int k;
        r.mant = '0; r.ex = e; r.sh = '0; r.dn = '0; r.zr = '0; r.acc = 0;
        for (int i = 0; i < int'(L); i++) begin
            v = m[i*MW +: MW];
            if (e[i*EW +: EW] != '0) begin
                r.mant[i*MW +: MW] = v;
            end else if (v == '0) begin
                r.zr[i] = 1'b1;
            end else begin
                k = 0;
                while (!v[MW-1]) begin
                    v = v << 1;
                    k++;
                end
                v = v << 1;
                k++;
                r.mant[i*MW +: MW] = v;
                r.sh[i*SW +: SW]   = SW'(k);
                r.dn[i]            = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, expv);
        end
    endtask

    always @(posedge clk) edge_n++;

    // Per-cycle compare of the default instance against the reference queue.
    always @(negedge clk) begin
        res_t f;
        logic ov_e;
        int   k;
        if (reset) begin
            q.delete();
            mcnt     = 0;
            post_rst = 1'b1;
        end else begin
            ov_e = (q.size() > 0) && (edge_n >= q[0].acc + 1);
            chk("out_valid", 64'(ifc.out_valid), 64'(ov_e));
            chk("in_ready", 64'(ifc.in_ready), 64'(!(q.size() == 2 && !ifc.out_ready)));
            chk("denorm_cnt", 64'(cnt), 64'(mcnt));
            if (post_rst) begin
                post_rst = 1'b0;
                chk("rst_mant", 64'(ifc.out_mant), 64'(0));
                chk("rst_exp", 64'(ifc.out_exp), 64'(0));
                chk("rst_flags", 64'({ifc.out_shift, ifc.out_denorm, ifc.out_zero}), 64'(0));
            end
            if (ifc.out_valid && ov_e) begin
                chk("mant", 64'(ifc.out_mant), 64'(q[0].mant));
                chk("exp", 64'(ifc.out_exp), 64'(q[0].ex));
                chk("shift", 64'(ifc.out_shift), 64'(q[0].sh));
                chk("denorm", 64'(ifc.out_denorm), 64'(q[0].dn));
                chk("zero", 64'(ifc.out_zero), 64'(q[0].zr));
                if (ifc.out_ready) begin
                    k    = $countones(q[0].dn);
                    mcnt = (mcnt + k > 65535) ? 65535 : mcnt + k;
                    void'(q.pop_front());
                end
            end
            if (ifc.in_valid && ifc.in_ready) begin
                f     = model(ifc.in_mant, ifc.in_exp);
                f.acc = edge_n + 1;
                q.push_back(f);
            end
        end
    end

    task automatic rand_in();
        for (int i = 0; i < int'(L); i++) begin
            if ($urandom_range(0, 5) == 0) ifc.in_mant[i*MW +: MW] = '0;
            else ifc.in_mant[i*MW +: MW] = MW'($urandom() >> $urandom_range(0, 31));
            ifc.in_exp[i*EW +: EW] = ($urandom_range(0, 2) == 0) ? EW'($urandom_range(1, 255)) : '0;
        end
    endtask

    // Present one transaction, then count falling edges until out_valid (bounded).
    task automatic send_wait(input logic [L*MW-1:0] m, input logic [L*EW-1:0] e, output int lat);
        ifc.in_valid = 1'b1;
        ifc.in_mant  = m;
        ifc.in_exp   = e;
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            lat++;
            if (ifc.out_valid) break;
        end
    endtask

    int lat;
    int prev_c;
    int cexp[5] = '{2, 4, 6, 7, 7};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        ifc.in_valid = 1'b0;   ifc.in_mant = '0;   ifc.in_exp = '0;   ifc.out_ready = 1'b1;
        ifc_c.in_valid = 1'b0; ifc_c.in_mant = '0; ifc_c.in_exp = '0; ifc_c.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        // Directed single transactions with hand-computed results.
        send_wait({23'h200001, 23'h400000}, 16'h0000, lat);
        chk("lat_a", 64'(lat), 64'(2));
        chk("a0_shift", 64'(ifc.out_shift[4:0]), 64'(1));
        chk("a0_mant", 64'(ifc.out_mant[22:0]), 64'(0));
        chk("a0_dn", 64'(ifc.out_denorm[0]), 64'(1));
        chk("a1_shift", 64'(ifc.out_shift[9:5]), 64'(2));
        chk("a1_mant", 64'(ifc.out_mant[45:23]), 64'h4);
        @(posedge clk); #1;

        send_wait({23'h000000, 23'h000001}, 16'h0000, lat);
        chk("b0_shift", 64'(ifc.out_shift[4:0]), 64'(23));
        chk("b0_mant", 64'(ifc.out_mant[22:0]), 64'(0));
        chk("b1_zero", 64'(ifc.out_zero[1]), 64'(1));
        chk("b1_shift", 64'(ifc.out_shift[9:5]), 64'(0));
        chk("b1_dn", 64'(ifc.out_denorm[1]), 64'(0));
        @(posedge clk); #1;

        send_wait({23'h000000, 23'h123456}, 16'h007F, lat);
        chk("c0_shift", 64'(ifc.out_shift[4:0]), 64'(0));
        chk("c0_mant", 64'(ifc.out_mant[22:0]), 64'h123456);
        chk("c0_exp", 64'(ifc.out_exp[7:0]), 64'h7F);
        chk("c0_dn", 64'(ifc.out_denorm[0]), 64'(0));
        chk("c1_zero", 64'(ifc.out_zero[1]), 64'(1));
        @(posedge clk); #1;
        repeat (2) @(posedge clk);
        #1;
        chk("cnt_after_directed", 64'(cnt), 64'(3));

        // Back-to-back streaming with downstream always ready.
        for (int n = 0; n < 100; n++) begin
            ifc.in_valid = 1'b1;
            rand_in();
            @(posedge clk);
            #1;
        end
        ifc.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Random backpressure.
        for (int n = 0; n < 400; n++) begin
            ifc.in_valid  = 1'($urandom_range(0, 1));
            ifc.out_ready = 1'($urandom_range(0, 1));
            rand_in();
            @(posedge clk);
            #1;
        end
        ifc.in_valid  = 1'b0;
        ifc.out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // Fill both stages while stalled, then reset.
        ifc.out_ready = 1'b0;
        ifc.in_valid  = 1'b1;
        repeat (3) begin
            rand_in();
            @(posedge clk);
            #1;
        end
        chk("full_in_ready", 64'(ifc.in_ready), 64'(0));
        ifc.in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        ifc.out_ready = 1'b1;
        chk("rst_out_valid", 64'(ifc.out_valid), 64'(0));
        chk("rst_in_ready", 64'(ifc.in_ready), 64'(1));
        chk("rst_cnt", 64'(cnt), 64'(0));
        @(posedge clk); #1;
        send_wait({23'h200001, 23'h400000}, 16'h0000, lat);
        chk("lat_post_rst", 64'(lat), 64'(2));
        chk("pr_a1_mant", 64'(ifc.out_mant[45:23]), 64'h4);
        @(posedge clk); #1;

        // Saturating counter on the CNT_W=3 instance: two denormals per result.
        prev_c = 0;
        for (int t = 0; t < 5; t++) begin
            ifc_c.out_ready = (t != 2);
            ifc_c.in_valid  = 1'b1;
            ifc_c.in_mant   = {23'h000100, 23'h400000};
            ifc_c.in_exp    = '0;
            @(posedge clk);
            #1;
            ifc_c.in_valid = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (ifc_c.out_valid) break;
            end
            chk("c_out_valid", 64'(ifc_c.out_valid), 64'(1));
            if (t == 2) begin
                repeat (3) begin
                    @(negedge clk);
                    chk("c_hold", 64'(cnt_c), 64'(prev_c));
                end
                ifc_c.out_ready = 1'b1;
            end
            @(posedge clk);
            #1;
            chk("c_cnt", 64'(cnt_c), 64'(cexp[t]));
            prev_c = cexp[t];
        end
        repeat (2) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/prenorm_pipe.md
# prenorm_pipe

Pipelined, multi-lane denormal pre-normaliser for the FIR floating-point datapath. Each lane takes a mantissa/exponent pair and classifies it as normal, denormal or zero. For a denormal, it finds the leading one, left-shifts the mantissa so that bit drops into the implicit position, and reports the shift. All lanes share one valid/ready handshake, with a 2-cycle pipeline and full backpressure. A saturating counter reports how many denormals have been normalised.

## Interface
Parameters:
- MANT_W, 23, stored mantissa width (excludes hidden bit); must be ≥ 2
- EXP_W, 8, biased exponent width
- LANES, 2, independent operand lanes per transaction
- SHW, $clog2(MANT_W+1), shift-count width (5 for defaults)
- CNT_W, 16, denormal counter width

Ports:
- clk, input, 1, single clock, rising edge
- reset, input, 1, synchronous, active-high
- in_valid, input, 1, transaction present
- in_ready, output, 1, block accepts the transaction this cycle
- in_mant, input, LANES*MANT_W, lane i at [i*MANT_W +: MANT_W]
- in_exp, input, LANES*EXP_W, lane i at [i*EXP_W +: EXP_W]
- out_valid, output, 1, result present
- out_ready, input, 1, downstream accepts the result
- out_mant, output, LANES*MANT_W, normalised mantissa per lane
- out_exp, output, LANES*EXP_W, input exponent passed through unchanged
- out_shift, output, LANES*SHW, left-shift applied per lane
- out_denorm, output, LANES, lane was denormal and was shifted
- out_zero, output, LANES, lane was exponent 0 and mantissa 0
- denorm_cnt, output, CNT_W, saturating count of normalised denormal lanes

## Operation
- Lane classification:
  - exp≠0 → normal: shift=0, mant passed through, denorm=0, zero=0.
  - exp=0, mant≠0 → denormal.
  - exp=0, mant=0 → zero: shift=0, mant=0, zero=1, denorm=0.
- Denormal handling:
  - shift = (MANT_W−1 − index of highest set bit) + 1, giving a range of 1..MANT_W.
  - Example: bit MANT_W−1 set → shift 1; only bit 0 set → shift MANT_W.
  - out_mant = (mant << shift) truncated to MANT_W bits; the leading one becomes the implicit bit and is discarded.
  - denorm=1.
- Lanes are fully independent. A transaction is atomic: all lanes move together.
- Stage 1 (S1) registers the input fields, the lane class and the leading-zero count. Stage 2 (S2) registers the shifted mantissa and the final outputs.
- Pipeline enables:
  - s2_en = !s2_valid || out_ready
  - s1_en = !s1_valid || s2_en
  - in_ready = s1_en, a combinational function of state and out_ready only.
- Transfers:
  - An input is accepted when in_valid && in_ready.
  - A result is consumed when out_valid && out_ready.
- denorm_cnt:
  - Adds the popcount of out_denorm on each consumed result.
  - Saturates at 2^CNT_W−1 and never wraps.
- Reset: clears s1_valid, s2_valid and denorm_cnt. Any in-flight transactions are discarded.
- Reset values:
  - out_valid=0, in_ready=1 (combinational, once reset is released)
  - out_mant=0, out_exp=0, out_shift=0, out_denorm=0, out_zero=0, denorm_cnt=0

## Timing
- Latency: 2 cycles from the accepting edge to out_valid, with no stall.
- Throughput: 1 transaction per cycle while out_ready=1.
- Stall (out_ready=0 with out_valid=1):
  - Output data is held stable.
  - S1 still fills if empty, so two transactions are buffered.
  - in_ready then drops in the same cycle.
- No bubbles on release: when out_ready rises, S2 consumes, S1 moves to S2 and a new input is accepted, all on the same edge.
- Simultaneous accept and consume on the same edge: both happen. No transaction is lost or duplicated.
- Data while out_valid=0: contents are don't-care, except immediately after reset, when they are 0.
- Counter at saturation: a consumed result holding k denormals leaves the count at max.
- Reset while stalled and full: the next cycle shows out_valid=0 and in_ready=1, and no stale result is ever presented.

## Test plan
Default parameters unless stated.
- **Single denormals** (lane0 exp=0):
  - mant=0x400000 → shift=1, out_mant=0x000000, denorm=1.
  - mant=0x200001 → shift=2, out_mant=0x000004.
  - mant=0x000001 → shift=23, out_mant=0.
- **Classification:**
  - lane0 exp=0x7F mant=0x123456 → shift=0, out_mant=0x123456, denorm=0.
  - lane1 exp=0 mant=0 → zero=1, shift=0.
  - Lane results are independent in the same transaction.
- **Streaming:** 100 back-to-back random transactions with out_ready=1 → in_ready stays 1, each result appears exactly 2 cycles later, in order, matching the reference model.
- **Backpressure:** random out_ready (50%) with random in_valid → no loss, duplication or reordering; outputs stable while stalled; in_ready=0 only when both stages are full and out_ready=0.
- **Counter:** CNT_W=3, stream 5 transactions each with 2 denormal lanes → denorm_cnt goes 2,4,6,7,7; no increment while out_ready=0.
- **Reset:** assert reset with both stages full and stalled → next cycle out_valid=0, in_ready=1, denorm_cnt=0, all data outputs 0; first post-reset input emerges after 2 cycles.
